// File: rtl/mux_rr_pipe.sv
// N-to-1 stream mux with valid/ready per channel and one registered output stage.
// Arbitration is fixed-select (sel) or round-robin, with optional packet locking.
module mux_rr_pipe #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int RR  = 1,
  parameter int PKT = 0,
  localparam int CW = ($clog2(NCH) < 1) ? 1 : $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH-1:0]   in_last,
  output logic [NCH-1:0]   in_ready,
  input  logic [CW-1:0]    sel,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_ch,
  output logic             out_valid,
  input  logic             out_ready
);

  logic          load_en;
  logic          gnt;
  logic [CW-1:0] g;
  logic [W-1:0]  dsel;
  logic          last_g;
  logic [CW-1:0] ptr;
  logic          lock;
  logic [CW-1:0] lock_ch;
  int            best;

  // Reset gates ready so no producer sees a handshake that reset discards.
  assign load_en = (!out_valid || out_ready) && !rst;

  always_comb begin
    gnt  = 1'b0;
    g    = '0;
    best = NCH;
    if (RR == 0) begin
      for (int c = 0; c < NCH; c++)
        if (sel == CW'(c) && in_valid[c]) begin
          gnt = 1'b1;
          g   = CW'(c);
        end
    end else if (lock) begin
      for (int c = 0; c < NCH; c++)
        if (lock_ch == CW'(c) && in_valid[c]) begin
          gnt = 1'b1;
          g   = CW'(c);
        end
    end else begin
      // Smallest rotational distance from ptr wins; wraps modulo NCH.
      for (int c = 0; c < NCH; c++)
        if (in_valid[c] && ((c + NCH - int'(ptr)) % NCH) < best) begin
          best = (c + NCH - int'(ptr)) % NCH;
          gnt  = 1'b1;
          g    = CW'(c);
        end
    end
  end

  always_comb begin
    dsel     = '0;
    last_g   = 1'b0;
    in_ready = '0;
    for (int c = 0; c < NCH; c++) begin
      if (g == CW'(c)) begin
        dsel   = in_data[c*W +: W];
        last_g = in_last[c];
      end
      in_ready[c] = gnt && load_en && (g == CW'(c));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
      lock      <= 1'b0;
      lock_ch   <= '0;
    end else if (load_en) begin
      if (gnt) begin
        out_data  <= dsel;
        out_ch    <= g;
        out_valid <= 1'b1;
        if (RR != 0 && PKT != 0 && !last_g) begin
          lock    <= 1'b1;
          lock_ch <= g;
        end else begin
          lock <= 1'b0;
          ptr  <= (int'(g) == NCH - 1) ? '0 : g + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
